// File: rtl/sequencer_pkg.sv
// Shared types and opcode decode for the FSA sequencer.
// Opcode classes map to instruction lengths inside sequencer_fsa.
package sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } mode_t;

    typedef enum logic [2:0] {
        CLS_SHORT,
        CLS_MOV16,
        CLS_LDST,
        CLS_INC,
        CLS_GOTO
    } op_class_t;

    localparam logic [7:0] HALT_OPCODE = 8'hAE;
    localparam logic [7:0] HI2_MASK    = 8'hC0;
    localparam logic [7:0] HI4_MASK    = 8'hF0;
    localparam logic [7:0] GOTO_MATCH  = 8'hC0;
    localparam logic [7:0] LDST_MATCH  = 8'h90;
    localparam logic [7:0] MOV16_MATCH = 8'hA0;
    localparam logic [7:0] INC_OPCODE  = 8'hB0;
    localparam logic [4:0] FETCH_LEN   = 5'd8;

    function automatic op_class_t classify(input logic [7:0] op);
        op_class_t c;
        c = CLS_SHORT;
        unique case (1'b1)
            ((op & HI2_MASK) == GOTO_MATCH):  c = CLS_GOTO;
            ((op & HI4_MASK) == LDST_MATCH):  c = CLS_LDST;
            ((op & HI4_MASK) == MOV16_MATCH): c = CLS_MOV16;
            (op == INC_OPCODE):               c = CLS_INC;
            default:                          c = CLS_SHORT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Registers a level input and emits a one-cycle pulse on its rising edge.
// Used for front-panel style controls such as single-step.
module step_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/sequencer_fsa.sv
// Per-instruction state sequencer feeding the decoder's FSA vector.
// Length is picked from the opcode class on leaving the last fetch state.
module sequencer_fsa
    import sequencer_pkg::*;
#(
    parameter int unsigned LEN_SHORT = 8,
    parameter int unsigned LEN_MOV16 = 10,
    parameter int unsigned LEN_LDST  = 12,
    parameter int unsigned LEN_INC   = 14,
    parameter int unsigned LEN_GOTO  = 24
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic       step,
    input  logic       resume,
    input  logic [7:0] inst_op,
    output logic [7:0] fsa_out,
    output logic       inst_end,
    output logic       halted
);

    if (LEN_SHORT < 8 || LEN_SHORT > 24 ||
        LEN_MOV16 < 8 || LEN_MOV16 > 24 ||
        LEN_LDST  < 8 || LEN_LDST  > 24 ||
        LEN_INC   < 8 || LEN_INC   > 24 ||
        LEN_GOTO  < 8 || LEN_GOTO  > 24) begin : g_len_check
        $error("sequencer_fsa: instruction lengths must lie in 8..24");
    end

    function automatic logic [4:0] class_len(input op_class_t c);
        logic [4:0] n;
        n = 5'(LEN_SHORT);
        unique case (c)
            CLS_MOV16: n = 5'(LEN_MOV16);
            CLS_LDST:  n = 5'(LEN_LDST);
            CLS_INC:   n = 5'(LEN_INC);
            CLS_GOTO:  n = 5'(LEN_GOTO);
            default:   n = 5'(LEN_SHORT);
        endcase
        return n;
    endfunction

    mode_t      mode_q, mode_d;
    logic [4:0] state_q, state_d;
    logic [4:0] len_q, len_d;
    logic       halt_q, halt_d;
    logic [7:0] fsa_d;
    logic       end_d;
    logic       step_rise;
    logic       advance;
    logic [4:0] op_len;
    logic       fin;
    logic       fin_halt;
    logic       last_d;
    logic       fetch_d;

    step_edge_detect u_step (
        .clk   (clock),
        .rst_n (reset_n),
        .din   (step),
        .rise  (step_rise)
    );

    // run dominates: a coincident step edge never adds a second advance
    assign advance = run | step_rise;
    assign op_len  = class_len(classify(inst_op));

    always_comb begin
        mode_d   = mode_q;
        state_d  = state_q;
        len_d    = len_q;
        halt_d   = halt_q;
        end_d    = 1'b0;
        fin      = 1'b0;
        fin_halt = 1'b0;

        unique case (mode_q)
            IDLE: begin
                if (advance) begin
                    mode_d  = RUN;
                    state_d = 5'd1;
                end
            end
            RUN: begin
                if (advance) begin
                    if (state_q < FETCH_LEN) begin
                        state_d = state_q + 5'd1;
                    end else if (state_q == FETCH_LEN) begin
                        if (op_len > FETCH_LEN) begin
                            state_d = FETCH_LEN + 5'd1;
                            len_d   = op_len;
                            halt_d  = (inst_op == HALT_OPCODE);
                        end else begin
                            fin      = 1'b1;
                            fin_halt = (inst_op == HALT_OPCODE);
                        end
                    end else if (state_q >= len_q) begin
                        fin      = 1'b1;
                        fin_halt = halt_q;
                    end else begin
                        state_d = state_q + 5'd1;
                    end
                end
            end
            HALTED: begin
                if (resume) begin
                    mode_d = IDLE;
                end
            end
            default: mode_d = IDLE;
        endcase

        if (fin) begin
            end_d  = 1'b1;
            len_d  = 5'(LEN_SHORT);
            halt_d = 1'b0;
            if (fin_halt) begin
                mode_d  = HALTED;
                state_d = 5'd0;
            end else begin
                state_d = 5'd1;
            end
        end
    end

    // State-8 last flag is a look-ahead on inst_op, which the
    // instruction register has loaded by the time fetch reaches 8.
    always_comb begin
        last_d  = 1'b0;
        fetch_d = 1'b0;
        if (mode_d == RUN) begin
            fetch_d = (state_d <= FETCH_LEN);
            if (state_d == FETCH_LEN) begin
                last_d = (op_len <= FETCH_LEN);
            end else if (state_d > FETCH_LEN) begin
                last_d = (state_d == len_d);
            end
        end
        fsa_d = {(mode_d == HALTED), last_d, fetch_d,
                 (mode_d == RUN) ? state_d : 5'd0};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= IDLE;
            state_q  <= 5'd0;
            len_q    <= 5'(LEN_SHORT);
            halt_q   <= 1'b0;
            fsa_out  <= 8'h00;
            inst_end <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            state_q  <= state_d;
            len_q    <= len_d;
            halt_q   <= halt_d;
            fsa_out  <= fsa_d;
            inst_end <= end_d;
        end
    end

    assign halted = fsa_out[7];

endmodule

// File: tb/tb_sequencer_fsa.sv
// Scoreboard bench for sequencer_fsa: stimulus queues expected outputs,
// a monitor pops and compares one entry per clock.
module tb_sequencer_fsa;

    logic       clock;
    logic       reset_n;
    logic       run;
    logic       step;
    logic       resume;
    logic [7:0] inst_op;
    logic [7:0] fsa_out;
    logic       inst_end;
    logic       halted;

    int errors = 0;
    int checks = 0;

    logic [8:0] sb_q[$];
    logic [8:0] mon_e;

    sequencer_fsa dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (run),
        .step     (step),
        .resume   (resume),
        .inst_op  (inst_op),
        .fsa_out  (fsa_out),
        .inst_end (inst_end),
        .halted   (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("fsa_out", fsa_out, mon_e[8:1]);
            check("inst_end", {7'd0, inst_end}, {7'd0, mon_e[0]});
            check("halted", {7'd0, halted}, {7'd0, mon_e[8]});
        end
    end

    task automatic tick(input logic [7:0] f, input logic e);
        sb_q.push_back({f, e});
        @(posedge clock);
        #2;
    endtask

    task automatic idle_tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [7:0] exp_fsa(input int k, input int len);
        logic [7:0] v;
        v = 8'(k);
        if (k <= 8) v[5] = 1'b1;
        if (k == len) v[6] = 1'b1;
        return v;
    endfunction

    // one instruction of len states; opcode presented after state 1
    task automatic instr(input logic [7:0] op, input int len,
                         input logic first_end);
        tick(exp_fsa(1, len), first_end);
        inst_op = op;
        for (int k = 2; k <= len; k++) tick(exp_fsa(k, len), 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_tick();
        idle_tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        resume  = 1'b0;
        inst_op = 8'h00;
        #3;
        check("reset_fsa", fsa_out, 8'h00);
        check("reset_end", {7'd0, inst_end}, 8'h00);
        check("reset_halted", {7'd0, halted}, 8'h00);
        idle_tick();
        idle_tick();
        reset_n = 1'b1;

        // short, short, goto x2, ldst, inc, mov16, then HALT
        run = 1'b1;
        instr(8'h00, 8, 1'b0);
        instr(8'h00, 8, 1'b1);
        instr(8'hC0, 24, 1'b1);
        instr(8'hC0, 24, 1'b1);
        instr(8'h90, 12, 1'b1);
        instr(8'hB0, 14, 1'b1);
        instr(8'hA0, 10, 1'b1);
        instr(8'hAE, 10, 1'b1);
        tick(8'h80, 1'b1);
        for (int i = 0; i < 19; i++) begin
            step = i[1];
            tick(8'h80, 1'b0);
        end
        step   = 1'b0;
        resume = 1'b1;
        tick(8'h00, 1'b0);
        resume = 1'b0;
        tick(exp_fsa(1, 8), 1'b0);
        run = 1'b0;
        tick(exp_fsa(1, 8), 1'b0);

        // single-step from idle
        do_reset();
        inst_op = 8'h00;
        tick(8'h00, 1'b0);
        for (int n = 1; n <= 3; n++) begin
            step = 1'b1;
            tick(exp_fsa(n, 8), 1'b0);
            tick(exp_fsa(n, 8), 1'b0);
            tick(exp_fsa(n, 8), 1'b0);
            step = 1'b0;
            tick(exp_fsa(n, 8), 1'b0);
            tick(exp_fsa(n, 8), 1'b0);
        end
        run  = 1'b1;
        step = 1'b1;
        tick(exp_fsa(4, 8), 1'b0);
        run = 1'b0;
        tick(exp_fsa(4, 8), 1'b0);
        tick(exp_fsa(4, 8), 1'b0);
        step = 1'b0;
        tick(exp_fsa(4, 8), 1'b0);

        // asynchronous reset in the middle of a GOTO
        do_reset();
        run = 1'b1;
        tick(exp_fsa(1, 24), 1'b0);
        inst_op = 8'hC0;
        for (int k = 2; k <= 17; k++) tick(exp_fsa(k, 24), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_fsa", fsa_out, 8'h00);
        check("async_rst_halted", {7'd0, halted}, 8'h00);
        idle_tick();
        inst_op = 8'h00;
        reset_n = 1'b1;
        instr(8'h00, 8, 1'b0);
        tick(exp_fsa(1, 8), 1'b1);
        run = 1'b0;
        idle_tick();

        check("sb_drained", 8'(sb_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
